// File: rtl/wide_add_pkg.sv
// wide_add_pkg: FSM encoding and sizing helpers shared by the chunked wide adder
package wide_add_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  function automatic int chunk_count(input int w, input int n);
    return w / n;
  endfunction
  function automatic int idx_width(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction
endpackage

// File: rtl/n_bit_cla_adder.sv
// n_bit_cla_adder: N-bit generate/propagate adder, one chunk of the wide add
module n_bit_cla_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         cin,
  output logic [N-1:0] SUM,
  output logic         cout
);
  logic [N-1:0] g, p;
  logic [N:0]   c;
  assign g = A & B;
  assign p = A ^ B;
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < N; i++) c[i+1] = g[i] | (p[i] & c[i]);
  end
  assign SUM  = p ^ c[N-1:0];
  assign cout = c[N];
endmodule

// File: rtl/wide_cla_add_seq.sv
// wide_cla_add_seq: W-bit add done as W/N passes through one shared N-bit CLA,
// LSB chunk first, carry chained through a register.
module wide_cla_add_seq
  import wide_add_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout
);
  localparam int CHUNKS = chunk_count(W, N);
  localparam int IW     = idx_width(CHUNKS);
  if (W % N != 0) begin : g_bad_width
    $error("wide_cla_add_seq: W must be a multiple of N");
  end
  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d, cout_q, cout_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [N-1:0]  add_sum;
  logic          add_cout, last, accept;
  n_bit_cla_adder #(.N(N)) u_cla (
    .A   (a_q[N-1:0]),
    .B   (b_q[N-1:0]),
    .cin (carry_q),
    .SUM (add_sum),
    .cout(add_cout)
  );
  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign last      = idx_q == IW'(CHUNKS - 1);
  assign out_valid = state_q == DONE;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = RUN;
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
        end else if (state_q == DONE && out_ready) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[idx_q*N +: N] = add_sum;
        carry_d = add_cout;
        a_d     = a_q >> N;
        b_d     = b_q >> N;
        idx_d   = last ? idx_q : idx_q + 1'b1;
        cout_d  = last ? add_cout : cout_q;
        state_d = last ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end
endmodule

// File: tb/tb_wide_cla_add_seq.sv
// tb_wide_cla_add_seq: scoreboard bench; expected sums pushed on accept, popped on result
module tb_wide_cla_add_seq;
  localparam int N = 32;
  localparam int W = 128;
  localparam int NUM_TESTS = 300;
  logic         clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, in_cin = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid, out_cout;
  logic [W-1:0] in_a = '0, in_b = '0, out_sum;
  logic [W:0]   sb[$];
  logic [W:0]   exp_r;
  int           n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;
  wide_cla_add_seq #(.N(N), .W(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout)
  );
  function automatic logic [W:0] golden(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction
  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_sum !== '0) begin n_fail++; $display("FAIL reset_out_sum got %h want 0", out_sum); end
    n_cmp++; if (out_cout !== 1'b0) begin n_fail++; $display("FAIL reset_out_cout got %b want 0", out_cout); end
    reset_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk);
  endtask
  task automatic test_carry_ripple();
    in_a = '1; in_b = '0; in_cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ripple_accept got %b want 1", in_ready); end
    sb.push_back(golden(in_a, in_b, in_cin));
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++;
      if (out_valid !== (k == 4)) begin n_fail++; $display("FAIL ripple_valid_timing cycle %0d got %b want %b", k, out_valid, k == 4); end
      if (out_valid === 1'b1 && sb.size() > 0) begin
        exp_r = sb.pop_front();
        n_cmp++;
        if ({out_cout, out_sum} !== exp_r) begin n_fail++; $display("FAIL ripple_result got %h want %h", {out_cout, out_sum}, exp_r); end
      end
      @(negedge clk);
    end
  endtask
  task automatic test_back_to_back();
    int got, t_res[2];
    logic drop;
    got = 0; drop = 1'b0;
    in_a = 1; in_b = 2; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    sb.push_back(golden(in_a, in_b, in_cin));
    @(negedge clk);
    in_a = {1'b1, {(W-1){1'b0}}}; in_b = {1'b1, {(W-1){1'b0}}};
    for (int t = 1; t < 20 && got < 2; t++) begin
      #1;
      if (out_valid === 1'b1) begin
        exp_r = sb.pop_front();
        n_cmp++;
        if ({out_cout, out_sum} !== exp_r) begin n_fail++; $display("FAIL b2b_result%0d got %h want %h", got, {out_cout, out_sum}, exp_r); end
        t_res[got] = t;
        got++;
      end
      if (in_valid && in_ready) begin
        n_cmp++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_in_done out_valid got %b want 1", out_valid); end
        sb.push_back(golden(in_a, in_b, in_cin));
        drop = 1'b1;
      end
      @(negedge clk);
      if (drop) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (got != 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", got); end
    else begin
      n_cmp++;
      if (t_res[1] - t_res[0] != 5) begin n_fail++; $display("FAIL b2b_spacing got %0d want 5", t_res[1] - t_res[0]); end
    end
  endtask
  task automatic test_backpressure();
    logic seen;
    in_a = W'(32'hFFFF_FFFF); in_b = 1; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    sb.push_back(golden(in_a, in_b, in_cin));
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (out_valid === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL bp_result_timeout got %b want 1", seen); end
    for (int k = 0; k < 10; k++) begin
      in_a = rnd(); in_b = rnd(); in_cin = 1'($urandom); in_valid = 1'b1;
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid cycle %0d got %b want 1", k, out_valid); end
      n_cmp++; if ({out_cout, out_sum} !== {1'b0, 128'h1_0000_0000}) begin n_fail++; $display("FAIL bp_hold_sum cycle %0d got %h want 100000000", k, {out_cout, out_sum}); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle %0d got %b want 0", k, in_ready); end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    exp_r = sb.pop_front();
    n_cmp++; if ({out_cout, out_sum} !== exp_r) begin n_fail++; $display("FAIL bp_release got %h want %h", {out_cout, out_sum}, exp_r); end
    @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_after_release got %b want 0", out_valid); end
    in_a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; in_b = 128'hFFFF_FFFF_0000_0001_FFFF_FFFF_8000_0000;
    in_cin = 1'b1; in_valid = 1'b1;
    #1;
    sb.push_back(golden(in_a, in_b, in_cin));
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        exp_r = sb.pop_front();
        n_cmp++; if ({out_cout, out_sum} !== exp_r) begin n_fail++; $display("FAIL bp_next_op got %h want %h", {out_cout, out_sum}, exp_r); end
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL bp_next_timeout got %b want 1", seen); end
  endtask
  task automatic test_reset_mid_op();
    int pulses;
    logic seen;
    in_a = rnd(); in_b = rnd(); in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (out_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL midrst_no_pulse got %0d want 0", pulses); end
    in_a = 5; in_b = 7; in_cin = 1'b1; in_valid = 1'b1;
    #1;
    sb.push_back(golden(in_a, in_b, in_cin));
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        exp_r = sb.pop_front();
        n_cmp++; if ({out_cout, out_sum} !== exp_r) begin n_fail++; $display("FAIL midrst_next got %h want %h", {out_cout, out_sum}, exp_r); end
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL midrst_timeout got %b want 1", seen); end
  endtask
  task automatic test_random();
    int sent, got;
    logic acc;
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 20000 && got < NUM_TESTS; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < NUM_TESTS && $urandom_range(0, 2) != 0) begin
        in_a = ($urandom_range(0, 9) == 0) ? '1 : rnd();
        in_b = ($urandom_range(0, 9) == 0) ? '1 : rnd();
        in_cin = 1'($urandom);
        in_valid = 1'b1;
      end
      #1;
      if (out_valid === 1'b1 && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL rand_unexpected got %h want none", {out_cout, out_sum}); end
        else begin
          exp_r = sb.pop_front();
          if ({out_cout, out_sum} !== exp_r) begin n_fail++; $display("FAIL rand_result%0d got %h want %h", got, {out_cout, out_sum}, exp_r); end
        end
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) begin sb.push_back(golden(in_a, in_b, in_cin)); sent++; end
      @(negedge clk);
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    n_cmp++; if (got != NUM_TESTS) begin n_fail++; $display("FAIL rand_count got %0d want %0d", got, NUM_TESTS); end
  endtask
  initial begin
    test_reset();
    test_carry_ripple();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
